sram_arbiter: RTL and testbench

- Shares the single external async SRAM (18-bit address, 8-bit data, active-low CS/OE/WE) between three requesters:
  - ARM SPI boot loader: write-only.
  - Video fetch: read-only.
  - 6502 CPU: read/write.
- Sequences each SRAM access as a fixed SETUP/ACCESS/HOLD cycle with fully registered strobes.
- The top level owns the DAT tristate, driven from DAT_out/DAT_oe.

---
 rtl/sram_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external asynchronous SRAM between three requesters
// (boot loader write-only, video fetch read-only, 6502 CPU read/write).
// Each access runs as SETUP (1 clk), ACCESS (ACCESS_CYCLES clks), HOLD (1 clk)
// with every SRAM strobe, the address and the pad data driven from flops.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   boot_req/addr/wdata -> boot_ack     boot write channel (highest priority)
//   vid_req/addr -> vid_rdata/vid_ack   video read channel
//   cpu_req/we/addr/wdata -> cpu_rdata/cpu_ack   CPU read/write channel
//   RAMCS_b, RAMOE_b, RAMWE_b, ADR      SRAM control and address (active-low strobes)
//   DAT_out, DAT_oe, DAT_in             split pad data; the top level builds the tristate
module sram_arbiter #(
    parameter int ADDR_WIDTH    = 18,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  boot_req,
    input  logic [ADDR_WIDTH-1:0] boot_addr,
    input  logic [7:0]            boot_wdata,
    output logic                  boot_ack,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [7:0]            vid_rdata,
    output logic                  vid_ack,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_ack,
    output logic                  RAMCS_b,
    output logic                  RAMOE_b,
    output logic                  RAMWE_b,
    output logic [ADDR_WIDTH-1:0] ADR,
    output logic [7:0]            DAT_out,
    input  logic [7:0]            DAT_in,
    output logic                  DAT_oe
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_BOOT = 2'd1,
        G_VID  = 2'd2,
        G_CPU  = 2'd3
    } grant_t;

    // Counter reloads with ACCESS_CYCLES-1 so ACCESS lasts exactly ACCESS_CYCLES clocks.
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    // Boot always wins; vid/cpu alternate via last_vid. The requester just served
    // is excluded for one edge so a held request cannot starve the other.
    function automatic grant_t arbitrate(input logic b, input logic v, input logic c,
                                         input grant_t mask, input logic last_vid);
        logic v_ok;
        logic c_ok;
        v_ok = v && (mask != G_VID);
        c_ok = c && (mask != G_CPU);
        if (b) begin
            return G_BOOT;
        end else if (v_ok && c_ok) begin
            return last_vid ? G_CPU : G_VID;
        end else if (v_ok) begin
            return G_VID;
        end else if (c_ok) begin
            return G_CPU;
        end else begin
            return G_NONE;
        end
    endfunction

    state_t                  state_r;
    state_t                  next_s;
    grant_t                  grant_r;
    grant_t                  win_s;
    grant_t                  mask_s;
    logic                    we_r;
    logic                    last_vid_r;
    logic [3:0]              cnt_r;
    logic                    load_s;
    logic                    sel_we_s;
    logic                    nxt_we_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [7:0]              sel_wdata_s;

    // Mask exists only on the HOLD exit edge.
    always_comb begin
        if (state_r == S_HOLD) begin
            mask_s = grant_r;
        end else begin
            mask_s = G_NONE;
        end
    end

    // Arbitration result and the request fields of the winner.
    always_comb begin
        win_s = arbitrate(boot_req, vid_req, cpu_req, mask_s, last_vid_r);
        case (win_s)
            G_BOOT: begin
                sel_addr_s  = boot_addr;
                sel_we_s    = 1'b1;
                sel_wdata_s = boot_wdata;
            end
            G_VID: begin
                sel_addr_s  = vid_addr;
                sel_we_s    = 1'b0;
                sel_wdata_s = 8'h00;
            end
            G_CPU: begin
                sel_addr_s  = cpu_addr;
                sel_we_s    = cpu_we;
                sel_wdata_s = cpu_wdata;
            end
            default: begin
                sel_addr_s  = {ADDR_WIDTH{1'b0}};
                sel_we_s    = 1'b0;
                sel_wdata_s = 8'h00;
            end
        endcase
    end

    // Next-state logic; load_s marks the edge that latches a new grant.
    always_comb begin
        next_s = state_r;
        load_s = 1'b0;
        case (state_r)
            S_IDLE, S_HOLD: begin
                if (win_s != G_NONE) begin
                    next_s = S_SETUP;
                    load_s = 1'b1;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_SETUP: begin
                next_s = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_r == 4'd0) begin
                    next_s = S_HOLD;
                end else begin
                    next_s = S_ACCESS;
                end
            end
            default: begin
                next_s = S_IDLE;
            end
        endcase
        nxt_we_s = load_s ? sel_we_s : we_r;
    end

    // State, grant latch and all registered SRAM-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            grant_r    <= G_NONE;
            we_r       <= 1'b0;
            last_vid_r <= 1'b1;
            cnt_r      <= 4'd0;
            RAMCS_b    <= 1'b1;
            RAMOE_b    <= 1'b1;
            RAMWE_b    <= 1'b1;
            ADR        <= {ADDR_WIDTH{1'b0}};
            DAT_out    <= 8'h00;
            DAT_oe     <= 1'b0;
            boot_ack   <= 1'b0;
            vid_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            vid_rdata  <= 8'h00;
            cpu_rdata  <= 8'h00;
        end else begin
            state_r  <= next_s;
            boot_ack <= 1'b0;
            vid_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            if (load_s) begin
                grant_r <= win_s;
                we_r    <= sel_we_s;
                ADR     <= sel_addr_s;
                DAT_out <= sel_wdata_s;
                if (win_s == G_VID) begin
                    last_vid_r <= 1'b1;
                end else if (win_s == G_CPU) begin
                    last_vid_r <= 1'b0;
                end else begin
                    last_vid_r <= last_vid_r;
                end
            end
            case (next_s)
                S_IDLE: begin
                    RAMCS_b <= 1'b1;
                    RAMOE_b <= 1'b1;
                    RAMWE_b <= 1'b1;
                    DAT_oe  <= 1'b0;
                end
                S_SETUP: begin
                    RAMCS_b <= 1'b0;
                    RAMOE_b <= nxt_we_s;
                    RAMWE_b <= 1'b1;
                    DAT_oe  <= nxt_we_s;
                end
                S_ACCESS: begin
                    RAMCS_b <= 1'b0;
                    RAMOE_b <= nxt_we_s;
                    RAMWE_b <= ~nxt_we_s;
                    DAT_oe  <= nxt_we_s;
                    if (state_r != S_ACCESS) begin
                        cnt_r <= CNT_LOAD;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                S_HOLD: begin
                    // WE rises here while ADR/DAT_out/DAT_oe stay put; read data
                    // is sampled on this edge while OE is still low.
                    RAMCS_b <= 1'b0;
                    RAMOE_b <= 1'b1;
                    RAMWE_b <= 1'b1;
                    case (grant_r)
                        G_BOOT: boot_ack <= 1'b1;
                        G_VID: begin
                            vid_ack <= 1'b1;
                            if (!we_r) begin
                                vid_rdata <= DAT_in;
                            end
                        end
                        G_CPU: begin
                            cpu_ack <= 1'b1;
                            if (!we_r) begin
                                cpu_rdata <= DAT_in;
                            end
                        end
                        default: begin
                            boot_ack <= 1'b0;
                        end
                    endcase
                end
                default: begin
                    RAMCS_b <= 1'b1;
                    RAMOE_b <= 1'b1;
                    RAMWE_b <= 1'b1;
                    DAT_oe  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default instance with a behavioural SRAM,
// plus ACCESS_CYCLES=1 and 15 instances for latency/strobe-width corners.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // Default instance (ACCESS_CYCLES = 2)
    logic        boot_req, boot_ack, vid_req, vid_ack, cpu_req, cpu_we, cpu_ack;
    logic [17:0] boot_addr, vid_addr, cpu_addr, ADR;
    logic [7:0]  boot_wdata, vid_rdata, cpu_wdata, cpu_rdata, DAT_out, DAT_in;
    logic        RAMCS_b, RAMOE_b, RAMWE_b, DAT_oe;

    sram_arbiter u_dut (
        .clk(clk), .reset(reset),
        .boot_req(boot_req), .boot_addr(boot_addr), .boot_wdata(boot_wdata), .boot_ack(boot_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .RAMCS_b(RAMCS_b), .RAMOE_b(RAMOE_b), .RAMWE_b(RAMWE_b), .ADR(ADR),
        .DAT_out(DAT_out), .DAT_in(DAT_in), .DAT_oe(DAT_oe)
    );

    // Parameter-corner instances: index 0 -> ACCESS_CYCLES=1, index 1 -> 15
    logic        p_req [2];
    logic        p_we  [2];
    logic        p_ack [2];
    logic        p_back[2];
    logic        p_vack[2];
    logic        p_csb [2];
    logic        p_oeb [2];
    logic        p_web [2];
    logic        p_doe [2];
    logic [7:0]  p_rdata[2];
    logic [7:0]  p_vrd [2];
    logic [7:0]  p_dout[2];
    logic [17:0] p_adr [2];

    sram_arbiter #(.ACCESS_CYCLES(1)) u_a1 (
        .clk(clk), .reset(reset),
        .boot_req(1'b0), .boot_addr(18'h00000), .boot_wdata(8'h00), .boot_ack(p_back[0]),
        .vid_req(1'b0), .vid_addr(18'h00000), .vid_rdata(p_vrd[0]), .vid_ack(p_vack[0]),
        .cpu_req(p_req[0]), .cpu_we(p_we[0]), .cpu_addr(18'h00100), .cpu_wdata(8'h77),
        .cpu_rdata(p_rdata[0]), .cpu_ack(p_ack[0]),
        .RAMCS_b(p_csb[0]), .RAMOE_b(p_oeb[0]), .RAMWE_b(p_web[0]), .ADR(p_adr[0]),
        .DAT_out(p_dout[0]), .DAT_in(8'h5A), .DAT_oe(p_doe[0])
    );

    sram_arbiter #(.ACCESS_CYCLES(15)) u_a15 (
        .clk(clk), .reset(reset),
        .boot_req(1'b0), .boot_addr(18'h00000), .boot_wdata(8'h00), .boot_ack(p_back[1]),
        .vid_req(1'b0), .vid_addr(18'h00000), .vid_rdata(p_vrd[1]), .vid_ack(p_vack[1]),
        .cpu_req(p_req[1]), .cpu_we(p_we[1]), .cpu_addr(18'h00100), .cpu_wdata(8'h77),
        .cpu_rdata(p_rdata[1]), .cpu_ack(p_ack[1]),
        .RAMCS_b(p_csb[1]), .RAMOE_b(p_oeb[1]), .RAMWE_b(p_web[1]), .ADR(p_adr[1]),
        .DAT_out(p_dout[1]), .DAT_in(8'hC3), .DAT_oe(p_doe[1])
    );

    // Behavioural SRAM for the default instance
    logic [7:0] mem [0:262143];
    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
        forever begin
            @(posedge clk);
            if (!RAMCS_b && !RAMWE_b) mem[ADR] <= DAT_out;
        end
    end
    assign DAT_in = (!RAMCS_b && !RAMOE_b) ? mem[ADR] : 8'hEE;

    // Bus-contention monitor across all instances
    int overlap = 0;
    always @(negedge clk) begin
        if ((DAT_oe && !RAMOE_b) || (p_doe[0] && !p_oeb[0]) || (p_doe[1] && !p_oeb[1]))
            overlap <= overlap + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One CPU access on the default instance; latency counted in negedges after request.
    task automatic cpu_op(input logic we, input logic [17:0] a, input logic [7:0] d,
                          output int lat, output int we_w);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        lat = -1; we_w = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (!RAMWE_b) we_w++;
            if (cpu_ack) begin
                lat = n;
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    // One CPU access on a parameter-corner instance.
    task automatic p_op(input int k, input logic we, output int lat, output int we_w,
                        output int oe_w);
        @(negedge clk);
        p_req[k] = 1'b1; p_we[k] = we;
        lat = -1; we_w = 0; oe_w = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (!p_web[k]) we_w++;
            if (!p_oeb[k]) oe_w++;
            if (p_ack[k]) begin
                lat = n;
                break;
            end
        end
        p_req[k] = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [17:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat, we_w, oe_w, acks, cnt, k, prev, bc, last_b, cpu_c, early;

        vecs[0] = '{1'b1, 18'h08000, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 18'h08000, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 18'h0FFFC, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 18'h0FFFC, 8'h00, 8'h00};
        vecs[4] = '{1'b0, 18'h00123, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 18'h3FFFF, 8'h3C, 8'h00};
        vecs[6] = '{1'b0, 18'h3FFFF, 8'h00, 8'h3C};
        vecs[7] = '{1'b1, 18'h08000, 8'h41, 8'h00};

        reset = 1'b1;
        boot_req = 1'b0; boot_addr = 18'h00000; boot_wdata = 8'h00;
        vid_req = 1'b0; vid_addr = 18'h00000;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 18'h00000; cpu_wdata = 8'h00;
        for (int i = 0; i < 2; i++) begin p_req[i] = 1'b0; p_we[i] = 1'b0; end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_strobes", {29'd0, RAMCS_b, RAMOE_b, RAMWE_b}, 32'h7);
        check("rst_adr_dat", {6'd0, ADR, DAT_out}, 32'h0);
        check("rst_oe_acks", {28'd0, DAT_oe, boot_ack, vid_ack, cpu_ack}, 32'h0);
        check("rst_rdata", {16'd0, vid_rdata, cpu_rdata}, 32'h0);

        // Idle for 100 clocks: nothing may move
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!RAMCS_b || !RAMOE_b || !RAMWE_b || DAT_oe || boot_ack || vid_ack || cpu_ack)
                cnt++;
        end
        check("idle_quiet", cnt, 0);

        // CPU transaction table
        for (int i = 0; i < 8; i++) begin
            cpu_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, we_w);
            check($sformatf("vec%0d_lat", i), lat, 4);
            check($sformatf("vec%0d_we_w", i), we_w, vecs[i].we ? 2 : 0);
            if (vecs[i].we) begin
                @(negedge clk);
                check($sformatf("vec%0d_mem", i), mem[vecs[i].addr], vecs[i].wdata);
            end else begin
                check($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
                check($sformatf("vec%0d_vid_rdata", i), vid_rdata, 8'h00);
            end
        end

        // Reset in the middle of a CPU write ACCESS
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h01234; cpu_wdata = 8'h99;
        repeat (2) @(negedge clk);
        check("mid_we_low", RAMWE_b, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_we", {30'd0, RAMWE_b, RAMCS_b}, 32'h3);
        check("mid_rst_ack", cpu_ack, 1'b0);
        check("mid_rst_rdata", cpu_rdata, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        acks = 0; lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (cpu_ack) begin
                acks++;
                if (lat < 0) lat = n;
                cpu_req = 1'b0;
            end
        end
        check("mid_redo_acks", acks, 1);
        check("mid_redo_lat", lat, 4);
        check("mid_redo_mem", mem[18'h01234], 8'h99);

        // vid and cpu held together: V,C,V,C,V,C every 4 clocks
        @(negedge clk);
        vid_req = 1'b1; vid_addr = 18'h08000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h0FFFC;
        k = 0; prev = 0;
        for (int c = 1; c <= 60 && k < 6; c++) begin
            @(negedge clk);
            if (vid_ack || cpu_ack) begin
                check($sformatf("alt%0d_who", k), {30'd0, vid_ack, cpu_ack},
                      (k % 2 == 0) ? 32'h2 : 32'h1);
                check($sformatf("alt%0d_gap", k), c - prev, 4);
                check($sformatf("alt%0d_vrd", k), vid_rdata, 8'h41);
                check($sformatf("alt%0d_crd", k), cpu_rdata, 8'h00);
                prev = c;
                k++;
                if (k == 6) begin
                    vid_req = 1'b0;
                    cpu_req = 1'b0;
                end
            end
        end
        check("alt_count", k, 6);

        // Boot stream of 16 bytes with cpu_req held throughout
        @(negedge clk);
        boot_req = 1'b1; boot_addr = 18'h0C000; boot_wdata = 8'h00;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h08000;
        bc = 0; last_b = 0; cpu_c = -1; early = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                if (bc < 16) early++;
                cpu_c = c;
                cpu_req = 1'b0;
                break;
            end
            if (boot_ack) begin
                check($sformatf("boot%0d_gap", bc), c - last_b, 4);
                last_b = c;
                bc++;
                if (bc < 16) begin
                    boot_addr = 18'h0C000 + 18'(bc);
                    boot_wdata = 8'(bc);
                end else begin
                    boot_req = 1'b0;
                end
            end
        end
        check("boot_count", bc, 16);
        check("boot_cpu_early", early, 0);
        check("boot_cpu_after", cpu_c - last_b, 4);
        check("boot_cpu_rdata", cpu_rdata, 8'h41);
        for (int i = 0; i < 16; i++)
            check($sformatf("boot_mem%0d", i), mem[18'h0C000 + 18'(i)], i);

        // ACCESS_CYCLES = 1 and 15 corners
        p_op(0, 1'b1, lat, we_w, oe_w);
        check("a1_wr_lat", lat, 3);
        check("a1_we_w", we_w, 1);
        p_op(0, 1'b0, lat, we_w, oe_w);
        check("a1_rd_lat", lat, 3);
        check("a1_oe_w", oe_w, 2);
        check("a1_rdata", p_rdata[0], 8'h5A);
        p_op(1, 1'b1, lat, we_w, oe_w);
        check("a15_wr_lat", lat, 17);
        check("a15_we_w", we_w, 15);
        p_op(1, 1'b0, lat, we_w, oe_w);
        check("a15_rd_lat", lat, 17);
        check("a15_oe_w", oe_w, 16);
        check("a15_rdata", p_rdata[1], 8'hC3);

        repeat (2) @(negedge clk);
        check("no_contention", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
